// File: rtl/cd_tx_ram_if.sv
// Host/tx-engine port bundle for cd_tx_ram. The host and tx engine sit on the
// master side and the frame buffer sits on the slave side.
interface cd_tx_ram_if #(
    parameter int P_WIDTH = 2
);
    // Handshake: every strobe (wr_en, commit, abort, rd_en, rd_done) is a
    // one-cycle pulse sampled on the rising clk edge. There is no backpressure.
    // The host reads has_free before writing. commit_fail reports a rejected
    // commit, and the tx engine only reads/releases while frm_valid is high.
    logic [7:0]       wr_byte;
    logic [7:0]       wr_addr;
    logic             wr_en;
    logic             commit;
    logic [7:0]       commit_len;
    logic             commit_fail;
    logic             has_free;
    logic             abort;
    logic             frm_valid;
    logic [7:0]       frm_len;
    logic [7:0]       rd_addr;
    logic             rd_en;
    logic [7:0]       rd_byte;
    logic             rd_done;
    logic [P_WIDTH:0] pending;

    modport master (
        output wr_byte, wr_addr, wr_en, commit, commit_len, abort,
               rd_addr, rd_en, rd_done,
        input  commit_fail, has_free, frm_valid, frm_len, rd_byte, pending
    );

    modport slave (
        input  wr_byte, wr_addr, wr_en, commit, commit_len, abort,
               rd_addr, rd_en, rd_done,
        output commit_fail, has_free, frm_valid, frm_len, rd_byte, pending
    );
endinterface

// File: rtl/cd_tx_ram.sv
// Multi-page transmit frame buffer: host fills/commits pages, tx engine reads and
// releases them in FIFO order. Define CD_TX_RAM_CNT_EN to add the sent_cnt port.
module cd_tx_ram #(
    parameter int P_WIDTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
`ifdef CD_TX_RAM_CNT_EN
    output logic [15:0]  sent_cnt,
`endif
    cd_tx_ram_if.slave   bus
);
    localparam int PAGES = 1 << P_WIDTH;
    localparam int AW    = P_WIDTH + 8;
    localparam logic [P_WIDTH:0] FULL = (P_WIDTH + 1)'(PAGES);
    localparam logic [P_WIDTH:0] ONE  = (P_WIDTH + 1)'(1);

    logic [7:0]         ram [0:(1 << AW) - 1];
    logic [7:0]         len_table [0:PAGES - 1];
    logic [P_WIDTH-1:0] wr_sel;
    logic [P_WIDTH-1:0] rd_sel;
    logic [P_WIDTH-1:0] wr_page_q;
    logic [P_WIDTH:0]   pending;
    logic [P_WIDTH:0]   pending_nxt;
    logic               wr_block;
    logic               wr_block_nxt;
    logic               wr_q;
    logic [7:0]         wr_addr_q;
    logic [7:0]         wr_byte_q;
    logic               full;
    logic               commit_ok;
    logic               commit_rej;
    logic               release_ok;

    always_comb begin
        full         = (pending == FULL);
        commit_ok    = bus.commit && !bus.abort && !wr_block && !full;
        commit_rej   = bus.commit && !bus.abort && (wr_block || full);
        release_ok   = bus.rd_done && !bus.abort && (pending != '0);

        pending_nxt  = pending;
        if (bus.abort) begin
            pending_nxt = '0;
        end else if (commit_ok && !release_ok) begin
            pending_nxt = pending + ONE;
        end else if (release_ok && !commit_ok) begin
            pending_nxt = pending - ONE;
        end

        // A commit always closes out the current page, so it clears a pending block
        // even when the final byte of that page was itself the blocked write.
        wr_block_nxt = wr_block;
        if (bus.abort || bus.commit) begin
            wr_block_nxt = 1'b0;
        end else if (bus.wr_en && full) begin
            wr_block_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_sel          <= '0;
            rd_sel          <= '0;
            wr_page_q       <= '0;
            pending         <= '0;
            wr_block        <= 1'b0;
            wr_q            <= 1'b0;
            bus.has_free    <= 1'b1;
            bus.commit_fail <= 1'b0;
            bus.frm_valid   <= 1'b0;
            bus.frm_len     <= '0;
            for (int i = 0; i < PAGES; i++) begin
                len_table[i] <= '0;
            end
        end else begin
            // The page is latched with the byte so a write sharing a cycle with
            // commit still lands in the page being committed.
            wr_q      <= bus.wr_en && !full;
            wr_page_q <= wr_sel;

            if (bus.abort) begin
                wr_sel <= '0;
                rd_sel <= '0;
            end else begin
                if (commit_ok) begin
                    len_table[wr_sel] <= bus.commit_len;
                    wr_sel            <= wr_sel + 1'b1;
                end
                if (release_ok) begin
                    rd_sel <= rd_sel + 1'b1;
                end
            end

            pending         <= pending_nxt;
            wr_block        <= wr_block_nxt;
            bus.has_free    <= (pending_nxt != FULL) && !wr_block_nxt;
            bus.commit_fail <= commit_rej;
            bus.frm_valid   <= (pending != '0) && !bus.rd_done && !bus.abort;
            bus.frm_len     <= len_table[rd_sel];
        end
    end

    always_ff @(posedge clk) begin
        wr_addr_q <= bus.wr_addr;
        wr_byte_q <= bus.wr_byte;
        if (wr_q) begin
            ram[{wr_page_q, wr_addr_q}] <= wr_byte_q;
        end
        if (bus.rd_en) begin
            bus.rd_byte <= ram[{rd_sel, bus.rd_addr}];
        end
    end

    assign bus.pending = pending;

`ifdef CD_TX_RAM_CNT_EN
    // Counts completed transmissions across aborts; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sent_cnt <= '0;
        end else if (release_ok) begin
            sent_cnt <= sent_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cd_tx_ram.sv
// Scoreboarded bench for cd_tx_ram: frame lengths queue in exp_q at commit and
// are checked at the head; a byte model checks read data.
module tb_cd_tx_ram;
  localparam int PW    = 2;
  localparam int PAGES = 1 << PW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cd_tx_ram_if #(.P_WIDTH(PW)) bus ();

`ifdef CD_TX_RAM_CNT_EN
  logic [15:0] sent_cnt;
  int m_sent = 0;
`endif

  cd_tx_ram #(.P_WIDTH(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef CD_TX_RAM_CNT_EN
    .sent_cnt(sent_cnt),
`endif
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mem_model [0:(PAGES*256)-1];
  int m_pending = 0;
  int m_wr_sel  = 0;
  int m_rd_sel  = 0;
  bit m_block   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_byte = '0; bus.wr_addr = '0; bus.wr_en = 1'b0;
    bus.commit = 1'b0; bus.commit_len = '0; bus.abort = 1'b0;
    bus.rd_addr = '0; bus.rd_en = 1'b0; bus.rd_done = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pending = 0; m_wr_sel = 0; m_rd_sel = 0; m_block = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pending"}, 32'(bus.pending), 32'(m_pending));
    check({tag, ".has_free"}, 32'(bus.has_free), 32'((m_pending != PAGES) && !m_block));
`ifdef CD_TX_RAM_CNT_EN
    check({tag, ".sent_cnt"}, 32'(sent_cnt), 32'(m_sent));
`endif
  endtask

  // One idle cycle lets the registered head outputs catch up with pending.
  task automatic check_head(input string tag);
    tick();
    check({tag, ".frm_valid"}, 32'(bus.frm_valid), 32'(m_pending != 0));
    if (m_pending != 0) check({tag, ".frm_len"}, 32'(bus.frm_len), 32'(exp_q[0]));
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [7:0] data);
    if (m_pending == PAGES) m_block = 1'b1;
    else mem_model[m_wr_sel*256 + int'(addr)] = data;
  endtask

  task automatic write(input logic [7:0] addr, input logic [7:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_byte = data;
    model_write(addr, data);
    tick();
    bus.wr_en = 1'b0;
    check_state("write");
  endtask

  // Drives commit / rd_done / abort together for one cycle and checks the response.
  task automatic ctl(input bit c, input logic [7:0] len, input bit d, input bit a, input string tag);
    bit exp_fail;
    bit ok;
    bit rel;
    exp_fail = 1'b0;
    if (a) begin
      model_reset();
    end else begin
      ok = c && !m_block && (m_pending != PAGES);
      exp_fail = c && !ok;
      rel = d && (m_pending != 0);
      if (rel) begin
        void'(exp_q.pop_front());
        m_rd_sel = (m_rd_sel + 1) % PAGES;
        m_pending--;
`ifdef CD_TX_RAM_CNT_EN
        m_sent++;
`endif
      end
      if (ok) begin
        exp_q.push_back(len);
        m_wr_sel = (m_wr_sel + 1) % PAGES;
        m_pending++;
      end
      if (c) m_block = 1'b0;
    end
    bus.commit = c; bus.commit_len = len; bus.rd_done = d; bus.abort = a;
    tick();
    bus.commit = 1'b0; bus.rd_done = 1'b0; bus.abort = 1'b0;
    check({tag, ".commit_fail"}, 32'(bus.commit_fail), 32'(exp_fail));
    check_state(tag);
    if (d || a) check({tag, ".frm_valid_low"}, 32'(bus.frm_valid), 32'd0);
  endtask

  task automatic wr_commit(input logic [7:0] addr, input logic [7:0] data, input logic [7:0] len);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_byte = data;
    model_write(addr, data);
    ctl(1'b1, len, 1'b0, 1'b0, "wr_commit");
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input string tag);
    bus.rd_en = 1'b1; bus.rd_addr = addr;
    tick();
    bus.rd_en = 1'b0;
    check(tag, 32'(bus.rd_byte), 32'(mem_model[m_rd_sel*256 + int'(addr)]));
  endtask

  task automatic send_frame(input logic [7:0] len, input bit same_cycle);
    for (int i = 0; i < int'(len); i++) write(8'(i), 8'($urandom_range(0, 255)));
    if (same_cycle) begin
      wr_commit(len, 8'($urandom_range(0, 255)), len);
    end else begin
      write(len, 8'($urandom_range(0, 255)));
      ctl(1'b1, len, 1'b0, 1'b0, "commit");
    end
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst.commit_fail", 32'(bus.commit_fail), 32'd0);
    check("rst.frm_valid", 32'(bus.frm_valid), 32'd0);
    check("rst.frm_len", 32'(bus.frm_len), 32'd0);
    reset_n = 1'b1;
    tick();
    check_state("rst");

    // Single frame, head outputs trail the commit by one cycle.
    for (int i = 0; i < 4; i++) write(8'(i), 8'(8'h11 + i));
    ctl(1'b1, 8'd3, 1'b0, 1'b0, "commit1");
    check("commit1.valid_lag", 32'(bus.frm_valid), 32'd0);
    check_head("frame1");
    for (int i = 0; i < 4; i++) rd(8'(i), "frame1.rd");
    ctl(1'b0, 8'd0, 1'b1, 1'b0, "done1");
    check_head("empty1");

    // Fill the ring, then a blocked write and a rejected commit.
    for (int k = 0; k < PAGES; k++) begin
      write(8'd0, 8'(8'hA0 + k));
      ctl(1'b1, 8'(k), 1'b0, 1'b0, "fill");
    end
    check_head("full");
    write(8'd0, 8'hEE);
    ctl(1'b1, 8'd0, 1'b0, 1'b0, "commit_full");
    tick();
    check("fail_pulse_end", 32'(bus.commit_fail), 32'd0);
    rd(8'd0, "full.rd_intact");

    // Commit with rd_done: rejected at full, accepted at pending=2.
    ctl(1'b1, 8'd7, 1'b1, 1'b0, "sim_full");
    check_head("sim_full");
    ctl(1'b0, 8'd0, 1'b1, 1'b0, "drain");
    check_head("drain");
    write(8'd0, 8'h77);
    ctl(1'b1, 8'd9, 1'b1, 1'b0, "sim2");
    check_head("sim2");

    // Random interleaved traffic, wrapping pages several times.
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        send_frame(8'($urandom_range(0, 3)), op == 1);
      end else if (op == 2) begin
        if (m_pending != 0) rd(8'($urandom_range(0, int'(exp_q[0]))), "rand.rd");
        ctl(1'b0, 8'd0, 1'b1, 1'b0, "rand.done");
      end else begin
        write(8'd0, 8'($urandom_range(0, 255)));
        ctl(1'b1, 8'd0, 1'b1, 1'b0, "rand.sim");
      end
      check_head("rand");
    end

    // Abort with three queued frames and a concurrent commit.
    while (m_pending < 3) send_frame(8'd1, 1'b0);
    while (m_pending > 3) ctl(1'b0, 8'd0, 1'b1, 1'b0, "pre_abort");
    ctl(1'b1, 8'd4, 1'b0, 1'b1, "abort");
    check_head("abort");
    wr_commit(8'd5, 8'h5A, 8'd5);
    check_head("post_abort");
    rd(8'd5, "post_abort.rd_page0");
    ctl(1'b0, 8'd0, 1'b1, 1'b0, "post_abort.done");
    ctl(1'b0, 8'd0, 1'b1, 1'b0, "done_empty");
    check_head("done_empty");

    // Reset with frames queued drops them.
    send_frame(8'd2, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
`ifdef CD_TX_RAM_CNT_EN
    m_sent = 0;
`endif
    tick();
    check_state("mid_reset");
    check_head("mid_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
